// File: rtl/harris_keypoint_extractor.sv
// Keypoint extractor: 3x3 non-maximum suppression on a raster corner-response stream,
// with surviving {x, y, score} queued in a FWFT FIFO plus per-frame statistics.
module harris_keypoint_extractor #(
    parameter int ImageW    = 640,
    parameter int ImageH    = 480,
    parameter int outW      = 8,
    parameter int FifoDepth = 16,
    parameter int XW        = $clog2(ImageW),
    parameter int YW        = $clog2(ImageH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [outW-1:0] cornerResponse,
    input  logic [outW-1:0] threshold,
    output logic            kp_valid,
    input  logic            kp_ready,
    output logic [XW-1:0]   kp_x,
    output logic [YW-1:0]   kp_y,
    output logic [outW-1:0] kp_score,
    output logic            frame_done,
    output logic [15:0]     kp_count,
    output logic [7:0]      drop_count,
    output logic            overflow
);
    localparam int AW = $clog2(FifoDepth);
    localparam int EW = XW + YW + outW;

    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [outW-1:0] r_lb0 [ImageW];
    logic [outW-1:0] r_lb1 [ImageW];
    logic [outW-1:0] r_ca [3];
    logic [outW-1:0] r_cb [3];
    logic [outW-1:0] w_n  [3];
    logic            w_x_last, w_y_last, w_elig, w_peak;
    logic [outW-1:0] w_c;

    // Incoming column, index 0 = oldest row (y-2), 2 = current row.
    assign w_n[0]   = r_lb1[r_x];
    assign w_n[1]   = r_lb0[r_x];
    assign w_n[2]   = cornerResponse;
    assign w_x_last = (r_x == XW'(ImageW - 1));
    assign w_y_last = (r_y == YW'(ImageH - 1));
    assign w_elig   = (r_x >= XW'(2)) && (r_y >= YW'(2));
    assign w_c      = r_cb[1];

    // Strict against earlier raster neighbours, non-strict against later ones,
    // so a plateau reports only its first pixel in raster order.
    assign w_peak = (w_c > threshold) &&
                    (w_c > r_ca[0]) && (w_c > r_cb[0]) && (w_c > w_n[0]) && (w_c > r_ca[1]) &&
                    (w_c >= w_n[1]) && (w_c >= r_ca[2]) && (w_c >= r_cb[2]) && (w_c >= w_n[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (en) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            r_lb1[r_x] <= r_lb0[r_x];
            r_lb0[r_x] <= cornerResponse;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_ca[i] <= '0;
                r_cb[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < 3; i++) begin
                r_ca[i] <= r_cb[i];
                r_cb[i] <= w_n[i];
            end
        end
    end

    // Candidate stage (E0)
    logic          r_cand_v;
    logic [EW-1:0] r_cand_d;
    logic          r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_v <= 1'b0;
            r_cand_d <= '0;
            r_last   <= 1'b0;
        end else begin
            r_cand_v <= en && w_elig && w_peak;
            r_cand_d <= {r_x - XW'(1), r_y - YW'(1), w_c};
            r_last   <= en && w_x_last && w_y_last;
        end
    end

    // Keypoint FIFO (E1 push), head held in a register so outputs are clean after reset.
    logic [EW-1:0] r_mem [FifoDepth];
    logic [EW-1:0] r_head;
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt, w_cnt_nxt;
    logic          r_kp_valid;
    logic          w_pop, w_full, w_push, w_drop, w_emptying;

    assign w_pop      = r_kp_valid && kp_ready;
    assign w_full     = (r_cnt == (AW+1)'(FifoDepth));
    assign w_push     = r_cand_v && (!w_full || w_pop);
    assign w_drop     = r_cand_v && w_full && !w_pop;
    assign w_emptying = (r_cnt == '0) || (w_pop && (r_cnt == (AW+1)'(1)));

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + (AW+1)'(1);
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= r_cand_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_kp_valid <= 1'b0;
            r_head     <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_cnt      <= w_cnt_nxt;
            r_kp_valid <= (w_cnt_nxt != '0);
            // A push into an (about to be) empty FIFO becomes the head directly.
            if (w_push && w_emptying)
                r_head <= r_cand_d;
            else if (w_pop && !w_emptying)
                r_head <= r_mem[r_rd + AW'(1)];
        end
    end

    assign kp_valid = r_kp_valid;
    assign kp_x     = r_head[EW-1 -: XW];
    assign kp_y     = r_head[outW+YW-1 -: YW];
    assign kp_score = r_head[outW-1:0];

    // Frame statistics
    logic [15:0] r_fcnt, r_kp_count, w_fcnt_inc;
    logic        r_frame_done, r_ovf;
    logic [7:0]  r_drop;

    assign w_fcnt_inc = (r_fcnt == 16'hFFFF) ? r_fcnt : r_fcnt + 16'(w_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt       <= '0;
            r_kp_count   <= '0;
            r_frame_done <= 1'b0;
            r_drop       <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_frame_done <= r_last;
            if (r_last) begin
                r_kp_count <= w_fcnt_inc;
                r_fcnt     <= '0;
            end else begin
                r_fcnt <= w_fcnt_inc;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != 8'hFF)
                    r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign frame_done = r_frame_done;
    assign kp_count   = r_kp_count;
    assign drop_count = r_drop;
    assign overflow   = r_ovf;

endmodule

// File: doc/harris_keypoint_extractor.md
Name: harris_keypoint_extractor

Overview:
Consumer end of the corner-response stream. It takes one unsigned response per `en` cycle in raster order. It performs 3x3 non-maximum suppression with a threshold and pushes surviving keypoints {x, y, score} into an output FIFO drained by a valid/ready handshake. It also reports per-frame keypoint count, cumulative drops and frame completion, and feeds the downstream SIFT descriptor stage.

Parameters:
ImageW, 640, pixels per line
ImageH, 480, lines per frame
outW, 8, response/score width (unsigned)
FifoDepth, 16, keypoint FIFO entries, power of 2, >=2
XW, $clog2(ImageW), x coordinate width
YW, $clog2(ImageH), y coordinate width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  cornerResponse valid this cycle
cornerResponse  input  outW  unsigned response, raster order
threshold  input  outW  unsigned minimum score, compared live
kp_valid  output  1  FIFO head valid
kp_ready  input  1  consumer accepts head
kp_x  output  XW  head x
kp_y  output  YW  head y
kp_score  output  outW  head response
frame_done  output  1  one-cycle pulse after last pixel of frame
kp_count  output  16  keypoints accepted in last completed frame
drop_count  output  8  keypoints dropped on full FIFO, saturates at 255
overflow  output  1  sticky, set on any drop

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FIFO empty; x/y counters 0; candidate register and per-frame count cleared. Line buffer contents are don't-care, because border gating masks them.
- Counters: on each en, x increments. When x=ImageW-1 it wraps to 0 and y increments. When y=ImageH-1 and x=ImageW-1, both wrap to 0.
- en=0: counters, line buffers and window do not change. The candidate/FIFO stages still push and pop.
- Window: two internal line buffers of ImageW x outW plus a 3x3 register window. When pixel (x,y) is accepted, the window centre C is at (x-1, y-1).
- Candidate eligible only when x>=2 and y>=2. The centre therefore lies in 1..ImageW-2, 1..ImageH-2; the border is never emitted.
- Keypoint condition (all unsigned):
  - C > threshold.
  - C > each earlier raster neighbour: TL, T, TR, L.
  - C >= each later neighbour: R, BL, B, BR.
  - Equal plateaus therefore yield only their earliest-raster pixel that satisfies the rule.
- Pipeline:
  - Edge E0 accepts the completing pixel; the decision and {x-1, y-1, C} are registered at E0.
  - Push into the FIFO happens at E1.
  - The FIFO is first-word-fall-through with registered outputs. kp_valid is high in the cycle after E1 when the FIFO was empty.
  - Total latency: 2 edges from the completing pixel to kp_valid.
- Pop: on an edge with kp_valid && kp_ready. The head advances, and kp_x/kp_y/kp_score hold stable while kp_valid && !kp_ready.
- Push while full without a simultaneous pop: the entry is dropped, drop_count is incremented (saturating at 255) and overflow is set. Both are cleared only by reset.
- Push and pop on the same edge while full: both take effect, with no drop. Push and pop while empty: the entry is written, then appears next cycle.
- Frame end: the edge E0 accepting (ImageW-1, ImageH-1) arms the frame end. At E1:
  - frame_done=1 for one cycle.
  - kp_count is loaded with the per-frame accepted count, including a push occurring at E1.
  - The per-frame counter restarts at 0, and the per-frame counter saturates at 16'hFFFF.
- FIFO entries are not flushed at frame end; order is strictly raster, across frames.
- Reset mid-frame: everything returns to its reset state immediately. The next en is pixel (0,0) and no stale keypoint is emitted.

Test Plan:
1. ImageW=8, ImageH=6, all responses 0, threshold 0 -> no kp_valid; frame_done pulses exactly once, 1 edge after the 48th en; kp_count=0.
2. Single 200 at (3,2), rest 10, threshold 50 -> one keypoint x=3 y=2 score=200; kp_valid rises 2 edges after pixel (4,3) is accepted; kp_count=1.
3. Plateau of 100 at (3,2) and (4,2), rest 10, threshold 50 -> only (3,2) emitted; kp_count=1.
4. Peaks of 255 at (0,0), (7,5), (7,2) and (3,0) -> no keypoints, kp_count=0.
5. FifoDepth=4, kp_ready=0, isolated 150 peaks at x∈{1,3,5}, y∈{1,3}, threshold 50 -> 4 stored, drop_count=2, overflow=1, kp_count=4. Then kp_ready=1 drains (1,1), (3,1), (5,1), (1,3) in order, one per cycle.
6. Assert rst_n low mid-frame with 2 keypoints queued, release, then send a full frame with a peak at (2,2) -> outputs 0 during reset; after it, only (2,2) is emitted; drop_count=0, overflow=0.
